// File: rtl/ps2_led_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_led_ctrl_if
// Bundles the byte paths around the LED sequencer:
//   scan_ready / scan_code  : bytes arriving from the PS/2 receiver
//   scan_ready_out          : gated strobe toward the scan-code decoder
//   tx_ready / tx_start /
//   tx_data                 : byte handshake with the PS/2 transmitter
// master : the LED sequencer (drives tx_start, tx_data, scan_ready_out)
// slave  : the PS/2 PHY side (drives scan_ready, scan_code, tx_ready)
// ---------------------------------------------------------------------------
interface ps2_led_ctrl_if;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       scan_ready_out;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  scan_ready, scan_code, tx_ready,
    output scan_ready_out, tx_start, tx_data
  );

  modport slave (
    output scan_ready, scan_code, tx_ready,
    input  scan_ready_out, tx_start, tx_data
  );
endinterface

// File: rtl/ps2_led_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_led_ctrl
// Keeps the keyboard lock LEDs in step with the requested levels by sending
// the "Set LEDs" command (0xED) followed by the LED argument byte, waiting for
// 0xFA after each byte. 0xFE or a silent keyboard triggers a bounded number
// of retransmissions before the transaction is abandoned. Acknowledge bytes
// arriving while a reply is awaited are hidden from the scan-code decoder.
//
// Ports:
//   clk                   system clock
//   reset_n               asynchronous active-low reset
//   led_scroll/num/caps   requested LED levels
//   bus (master)          receiver bytes in, gated strobe out, transmitter
//                         handshake out (see ps2_led_ctrl_if)
//   busy                  a Set-LEDs transaction is in progress
//   error                 one-cycle pulse when a transaction is abandoned
// ---------------------------------------------------------------------------
module ps2_led_ctrl #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          led_scroll,
  input  logic          led_num,
  input  logic          led_caps,
  ps2_led_ctrl_if.master bus,
  output logic          busy,
  output logic          error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CMD  = 3'd1;
  localparam logic [2:0] WAIT_ACK1 = 3'd2;
  localparam logic [2:0] SEND_ARG  = 3'd3;
  localparam logic [2:0] WAIT_ACK2 = 3'd4;
  localparam logic [2:0] ABORT     = 3'd5;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CODE_ACK     = 8'hFA;
  localparam logic [7:0] CODE_RESEND  = 8'hFE;
  localparam logic [7:0] CODE_BAT_OK  = 8'hAA;

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  logic [2:0]         state_reg;
  logic               tx_start_reg;
  logic [7:0]         tx_data_reg;
  logic               busy_reg;
  logic               error_reg;
  logic [2:0]         last_sent_reg;
  logic [2:0]         cur_arg_reg;
  logic               force_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [1:0]         sync_reg;
  logic [7:0]         code_reg;

  logic [2:0] led_byte;
  logic       rx_event;
  logic       rx_bat;
  logic       in_wait;
  logic       ack_like;

  assign led_byte = {led_caps, led_num, led_scroll};

  // sync_reg[0] is the newest sample; 2'b01 is the first cycle after a rise.
  // code_reg was loaded on the same edge as sync_reg[0], so it holds the byte
  // that accompanied the rising strobe.
  assign rx_event = (sync_reg == 2'b01);
  assign rx_bat   = rx_event && (code_reg == CODE_BAT_OK);

  assign in_wait  = (state_reg == WAIT_ACK1) || (state_reg == WAIT_ACK2);
  assign ack_like = (bus.scan_code == CODE_ACK) || (bus.scan_code == CODE_RESEND);

  assign bus.scan_ready_out = bus.scan_ready & ~(in_wait & ack_like);
  assign bus.tx_start       = tx_start_reg;
  assign bus.tx_data        = tx_data_reg;
  assign busy               = busy_reg;
  assign error              = error_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      busy_reg      <= 1'b0;
      error_reg     <= 1'b0;
      last_sent_reg <= 3'b000;
      cur_arg_reg   <= 3'b000;
      force_reg     <= 1'b1;
      retry_reg     <= '0;
      timer_reg     <= '0;
      sync_reg      <= 2'b00;
      code_reg      <= 8'h00;
    end else begin
      sync_reg     <= {sync_reg[0], bus.scan_ready};
      code_reg     <= bus.scan_code;
      tx_start_reg <= 1'b0;
      error_reg    <= 1'b0;

      // A keyboard that just finished its self-test has lost its LED state.
      if (rx_bat) begin
        force_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (force_reg || (led_byte != last_sent_reg)) begin
            state_reg   <= SEND_CMD;
            busy_reg    <= 1'b1;
            retry_reg   <= '0;
            cur_arg_reg <= led_byte;
            // A BAT arriving on this very edge still earns a resync later.
            force_reg   <= rx_bat;
          end
        end

        SEND_CMD, SEND_ARG: begin
          if (bus.tx_ready) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= (state_reg == SEND_CMD) ? CMD_SET_LEDS
                                                    : {5'b00000, cur_arg_reg};
            state_reg    <= (state_reg == SEND_CMD) ? WAIT_ACK1 : WAIT_ACK2;
            timer_reg    <= '0;
          end
        end

        WAIT_ACK1, WAIT_ACK2: begin
          if (timer_reg != TIMER_MAX) begin
            timer_reg <= timer_reg + 1'b1;
          end
          if (rx_event && (code_reg == CODE_ACK)) begin
            retry_reg <= '0;
            if (state_reg == WAIT_ACK1) begin
              state_reg <= SEND_ARG;
            end else begin
              last_sent_reg <= cur_arg_reg;
              busy_reg      <= 1'b0;
              state_reg     <= IDLE;
            end
          end else if ((rx_event && (code_reg == CODE_RESEND)) ||
                       (timer_reg == TIMER_LAST)) begin
            if (retry_reg == RETRY_LAST) begin
              state_reg <= ABORT;
            end else begin
              retry_reg <= retry_reg + 1'b1;
              state_reg <= (state_reg == WAIT_ACK1) ? SEND_CMD : SEND_ARG;
            end
          end
        end

        ABORT: begin
          // Record the byte as sent so a dead keyboard does not cause an
          // endless retry loop; a later LED change or BAT starts afresh.
          error_reg     <= 1'b1;
          last_sent_reg <= cur_arg_reg;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
